// File: rtl/stereo_pkg.sv
// Shared types and helpers for the block-matching disparity engine.
package stereo_pkg;

  typedef enum int unsigned {
    COST_SAD = 0,
    COST_SSD = 1
  } cost_mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StDrain,
    StCompare,
    StWrite,
    StDone
  } engine_state_e;

  // All-ones code of the given width, reported when no candidate is good enough.
  function automatic int unsigned invalid_code(input int unsigned disp_w);
    return (32'd1 << disp_w) - 32'd1;
  endfunction

endpackage

// File: rtl/block_cost_accum.sv
// Tags returning frame-buffer data and accumulates the per-pixel SAD or SSD term.
module block_cost_accum
  import stereo_pkg::*;
#(
  parameter int unsigned PIX_W        = 8,
  parameter int unsigned COST_W       = 23,
  parameter int unsigned COST_MODE    = 0,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic              clear,
  input  logic [PIX_W-1:0]  left_pix,
  input  logic [PIX_W-1:0]  right_pix,
  output logic [COST_W-1:0] cost
);

  logic [READ_LATENCY-1:0] tag_q;
  logic [COST_W-1:0]       acc_q;
  logic [PIX_W-1:0]        abs_diff;
  logic [2*PIX_W-1:0]      abs_wide;
  logic [2*PIX_W-1:0]      term;

  always_comb begin
    abs_diff = (left_pix >= right_pix) ? left_pix - right_pix : right_pix - left_pix;
    abs_wide = (2*PIX_W)'(abs_diff);
    if (COST_MODE == COST_SSD) begin
      term = abs_wide * abs_wide;
    end else begin
      term = abs_wide;
    end
  end

  // tag_q[READ_LATENCY-1] is high exactly when the pair issued READ_LATENCY cycles ago arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
      acc_q <= '0;
    end else begin
      tag_q[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      if (clear) begin
        acc_q <= '0;
      end else if (tag_q[READ_LATENCY-1]) begin
        acc_q <= acc_q + COST_W'(term);
      end
    end
  end

  assign cost = acc_q;

endmodule

// File: rtl/stereo_match_engine.sv
// Block-matching disparity engine: scans every anchor of a frame, keeps the lowest-cost
// disparity and writes one result per anchor.
module stereo_match_engine
  import stereo_pkg::*;
#(
  parameter int unsigned IMG_W        = 240,
  parameter int unsigned IMG_H        = 320,
  parameter int unsigned BLOCK        = 6,
  parameter int unsigned MAX_DISP     = 63,
  parameter int unsigned PIX_W        = 8,
  parameter int unsigned COST_MODE    = 0,
  parameter int unsigned READ_LATENCY = 2,
  localparam int unsigned DISP_W      = $clog2(MAX_DISP + 2),
  localparam int unsigned COST_W      = 2 * PIX_W + $clog2(BLOCK * BLOCK) + 1,
  localparam int unsigned ADDR_W      = $clog2(IMG_W * IMG_H),
  parameter logic [COST_W-1:0] COST_THRESH = '1
) (
  input  logic              clk_100mhz,
  input  logic              sys_rst,
  input  logic              start_in,
  output logic [ADDR_W-1:0] left_addr,
  output logic [ADDR_W-1:0] right_addr,
  input  logic [PIX_W-1:0]  left_din,
  input  logic [PIX_W-1:0]  right_din,
  output logic              result_we,
  output logic [ADDR_W-1:0] result_addr,
  output logic [DISP_W-1:0] result_disp,
  output logic [COST_W-1:0] result_cost,
  output logic              busy_out,
  output logic              done_out
);

  localparam int unsigned RC_W = $clog2(BLOCK + 1);
  localparam int unsigned XW   = $clog2(IMG_W + 1);
  localparam int unsigned YW   = $clog2(IMG_H + 1);
  localparam int unsigned LW   = $clog2(READ_LATENCY + 1);
  localparam logic [DISP_W-1:0] INVALID   = DISP_W'(invalid_code(DISP_W));
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W - BLOCK + 1);
  localparam logic [ADDR_W-1:0] WRAP_STEP = ADDR_W'(BLOCK);

  engine_state_e     state_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [DISP_W-1:0] d_q;
  logic [RC_W-1:0]   r_q;
  logic [RC_W-1:0]   c_q;
  logic [LW-1:0]     drain_q;
  logic [ADDR_W-1:0] base_q;
  logic [COST_W-1:0] best_cost_q;
  logic [DISP_W-1:0] best_disp_q;

  logic [COST_W-1:0] cost;
  logic              take;
  logic              d_last;
  logic              x_last;
  logic              y_last;
  logic              issue_last;
  logic              col_last;
  logic [COST_W-1:0] win_cost;
  logic [DISP_W-1:0] win_disp;
  logic [DISP_W-1:0] d_next;
  logic [ADDR_W-1:0] next_base;

  block_cost_accum #(
    .PIX_W        (PIX_W),
    .COST_W       (COST_W),
    .COST_MODE    (COST_MODE),
    .READ_LATENCY (READ_LATENCY)
  ) u_accum (
    .clk       (clk_100mhz),
    .rst       (sys_rst),
    .issue     (state_q == StIssue),
    .clear     (state_q == StCompare),
    .left_pix  (left_din),
    .right_pix (right_din),
    .cost      (cost)
  );

  always_comb begin
    // Strict less-than keeps the smallest disparity among equal costs.
    take       = (d_q == '0) || (cost < best_cost_q);
    win_cost   = take ? cost : best_cost_q;
    win_disp   = take ? d_q : best_disp_q;
    d_last     = (d_q == DISP_W'(MAX_DISP)) || (32'(d_q) == 32'(x_q));
    x_last     = (x_q == XW'(IMG_W - BLOCK));
    y_last     = (y_q == YW'(IMG_H - BLOCK));
    col_last   = (c_q == RC_W'(BLOCK - 1));
    issue_last = (r_q == RC_W'(BLOCK - 1)) && col_last;
    d_next     = d_q + DISP_W'(1);
    next_base  = x_last ? base_q + WRAP_STEP : base_q + ADDR_W'(1);
  end

  always_ff @(posedge clk_100mhz) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      drain_q     <= '0;
      base_q      <= '0;
      best_cost_q <= '0;
      best_disp_q <= '0;
      left_addr   <= '0;
      right_addr  <= '0;
      result_we   <= 1'b0;
      result_addr <= '0;
      result_disp <= '0;
      result_cost <= '0;
      busy_out    <= 1'b0;
      done_out    <= 1'b0;
    end else begin
      result_we <= 1'b0;
      done_out  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_in) begin
            state_q    <= StIssue;
            busy_out   <= 1'b1;
            x_q        <= '0;
            y_q        <= '0;
            d_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            base_q     <= '0;
            left_addr  <= '0;
            right_addr <= '0;
          end
        end
        StIssue: begin
          if (issue_last) begin
            state_q <= StDrain;
            drain_q <= '0;
          end else if (col_last) begin
            c_q        <= '0;
            r_q        <= r_q + RC_W'(1);
            left_addr  <= left_addr + ROW_STEP;
            right_addr <= right_addr + ROW_STEP;
          end else begin
            c_q        <= c_q + RC_W'(1);
            left_addr  <= left_addr + ADDR_W'(1);
            right_addr <= right_addr + ADDR_W'(1);
          end
        end
        StDrain: begin
          if (drain_q == LW'(READ_LATENCY - 1)) begin
            state_q <= StCompare;
          end else begin
            drain_q <= drain_q + LW'(1);
          end
        end
        StCompare: begin
          best_cost_q <= win_cost;
          best_disp_q <= win_disp;
          if (d_last) begin
            state_q     <= StWrite;
            result_we   <= 1'b1;
            result_addr <= base_q;
            result_cost <= win_cost;
            result_disp <= (win_cost > COST_THRESH) ? INVALID : win_disp;
          end else begin
            state_q    <= StIssue;
            d_q        <= d_next;
            r_q        <= '0;
            c_q        <= '0;
            left_addr  <= base_q;
            right_addr <= base_q - ADDR_W'(d_next);
          end
        end
        StWrite: begin
          if (x_last && y_last) begin
            state_q  <= StDone;
            done_out <= 1'b1;
            busy_out <= 1'b0;
          end else begin
            state_q    <= StIssue;
            base_q     <= next_base;
            left_addr  <= next_base;
            right_addr <= next_base;
            d_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            if (x_last) begin
              x_q <= '0;
              y_q <= y_q + YW'(1);
            end else begin
              x_q <= x_q + XW'(1);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stereo_match_engine.sv
// Self-checking bench: SAD and SSD engines on a 16x8 frame against a brute-force reference.
module tb_stereo_match_engine;

  localparam int W       = 16;
  localparam int H       = 8;
  localparam int B       = 3;
  localparam int MD      = 4;
  localparam int RL      = 2;
  localparam int NA      = (W - B + 1) * (H - B + 1);
  localparam int SAD_THR = (1 << 21) - 1;
  localparam int SSD_THR = 10;
  localparam int BUDGET  = 20000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start    [2];
  logic [6:0] l_addr   [2];
  logic [6:0] r_addr   [2];
  logic [6:0] res_addr [2];
  logic [7:0] l_din    [2];
  logic [7:0] r_din    [2];
  logic [7:0] l_p0     [2];
  logic [7:0] r_p0     [2];
  logic       we       [2];
  logic       busy     [2];
  logic       done     [2];
  logic [2:0] disp     [2];
  logic [20:0] cost    [2];

  logic [7:0] mem_l [W*H];
  logic [7:0] mem_r [W*H];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc;
  int done_cnt;
  bit busy_err;
  int q_addr[$], q_disp[$], q_cost[$], q_cyc[$];
  int exp_addr[NA], exp_disp[NA], exp_cost[NA];

  stereo_match_engine #(
    .IMG_W(W), .IMG_H(H), .BLOCK(B), .MAX_DISP(MD), .PIX_W(8), .COST_MODE(0),
    .READ_LATENCY(RL)
  ) dut_sad (
    .clk_100mhz(clk), .sys_rst(rst), .start_in(start[0]),
    .left_addr(l_addr[0]), .right_addr(r_addr[0]), .left_din(l_din[0]), .right_din(r_din[0]),
    .result_we(we[0]), .result_addr(res_addr[0]), .result_disp(disp[0]),
    .result_cost(cost[0]), .busy_out(busy[0]), .done_out(done[0])
  );

  stereo_match_engine #(
    .IMG_W(W), .IMG_H(H), .BLOCK(B), .MAX_DISP(MD), .PIX_W(8), .COST_MODE(1),
    .READ_LATENCY(RL), .COST_THRESH(21'd10)
  ) dut_ssd (
    .clk_100mhz(clk), .sys_rst(rst), .start_in(start[1]),
    .left_addr(l_addr[1]), .right_addr(r_addr[1]), .left_din(l_din[1]), .right_din(r_din[1]),
    .result_we(we[1]), .result_addr(res_addr[1]), .result_disp(disp[1]),
    .result_cost(cost[1]), .busy_out(busy[1]), .done_out(done[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Two-stage BRAM model per engine.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      l_p0[u]  <= mem_l[l_addr[u]];
      r_p0[u]  <= mem_r[r_addr[u]];
      l_din[u] <= l_p0[u];
      r_din[u] <= r_p0[u];
    end
  end

  task automatic build_ref(input int ssd, input int thr);
    int i, best, bd, c, diff, dmax;
    i = 0;
    for (int y = 0; y <= H - B; y++) begin
      for (int x = 0; x <= W - B; x++) begin
        best = 0;
        bd = 0;
        dmax = (x < MD) ? x : MD;
        for (int d = 0; d <= dmax; d++) begin
          c = 0;
          for (int r = 0; r < B; r++) begin
            for (int k = 0; k < B; k++) begin
              diff = int'(mem_l[(y+r)*W + x + k]) - int'(mem_r[(y+r)*W + x - d + k]);
              c += ssd ? diff * diff : ((diff < 0) ? -diff : diff);
            end
          end
          if (d == 0 || c < best) begin
            best = c;
            bd = d;
          end
        end
        exp_addr[i] = y * W + x;
        exp_cost[i] = best;
        exp_disp[i] = (best > thr) ? 7 : bd;
        i++;
      end
    end
  endtask

  // Called at a negedge; pulses start and records every result write until done.
  task automatic run_frame(input int u, input bit inject);
    int n;
    q_addr.delete(); q_disp.delete(); q_cost.delete(); q_cyc.delete();
    done_cnt = 0;
    busy_err = 0;
    start[u] = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start[u] = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < BUDGET) begin
      if (we[u]) begin
        q_addr.push_back(int'(res_addr[u])); q_disp.push_back(int'(disp[u]));
        q_cost.push_back(int'(cost[u])); q_cyc.push_back(cyc);
      end
      if (done[u]) done_cnt++;
      else if (!busy[u]) busy_err = 1;
      start[u] = inject && (n % 400 == 200);
      @(negedge clk);
      n++;
    end
    start[u] = 1'b0;
    checks++;
    if (n >= BUDGET) begin
      errors++;
      $display("FAIL frame_timeout u=%0d cycles=%0d limit=%0d", u, n, BUDGET);
    end
    repeat (4) begin
      if (we[u]) begin
        q_addr.push_back(int'(res_addr[u])); q_disp.push_back(int'(disp[u]));
        q_cost.push_back(int'(cost[u])); q_cyc.push_back(cyc);
      end
      if (done[u]) done_cnt++;
      if (busy[u]) busy_err = 1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({we[u], busy[u], done[u]} !== 3'b000) begin
        errors++;
        $display("FAIL reset_flags u=%0d got we/busy/done=%b want 000", u,
                 {we[u], busy[u], done[u]});
      end
      checks++;
      if ({l_addr[u], r_addr[u], res_addr[u]} !== 21'd0) begin
        errors++;
        $display("FAIL reset_addrs u=%0d got %0d %0d %0d want 0", u, l_addr[u], r_addr[u],
                 res_addr[u]);
      end
      checks++;
      if (disp[u] !== 3'd0 || cost[u] !== 21'd0) begin
        errors++;
        $display("FAIL reset_result u=%0d got disp=%0d cost=%0d want 0", u, disp[u], cost[u]);
      end
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy got %b%b want 00", busy[0], busy[1]);
    end
  endtask

  task automatic test_identical();
    for (int i = 0; i < W*H; i++) begin
      mem_l[i] = 8'($urandom);
      mem_r[i] = mem_l[i];
    end
    build_ref(0, SAD_THR);
    run_frame(0, 1'b0);
    checks++;
    if (q_addr.size() != NA || done_cnt != 1 || busy_err) begin
      errors++;
      $display("FAIL ident_frame got writes=%0d dones=%0d busy_err=%0d want %0d 1 0",
               q_addr.size(), done_cnt, busy_err, NA);
    end
    for (int i = 0; i < q_addr.size() && i < NA; i++) begin
      checks++;
      if (q_addr[i] != exp_addr[i] || q_disp[i] != exp_disp[i] || q_cost[i] != exp_cost[i]) begin
        errors++;
        $display("FAIL ident_result i=%0d got a=%0d d=%0d c=%0d want a=%0d d=%0d c=%0d", i,
                 q_addr[i], q_disp[i], q_cost[i], exp_addr[i], exp_disp[i], exp_cost[i]);
      end
    end
  endtask

  // Uses the write timestamps captured by the preceding frame.
  task automatic test_timing();
    int x, dmax, want, got;
    for (int i = 0; i < q_cyc.size() && i < NA; i++) begin
      x = exp_addr[i] % W;
      dmax = (x < MD) ? x : MD;
      want = (dmax + 1) * (B * B + RL + 1) + 1;
      got = (i == 0) ? q_cyc[0] - start_cyc : q_cyc[i] - q_cyc[i-1];
      checks++;
      if (got != want) begin
        errors++;
        $display("FAIL anchor_cycles i=%0d x=%0d got %0d want %0d", i, x, got, want);
      end
    end
  endtask

  task automatic test_shift();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) mem_l[y*W + x] = 8'($urandom);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        mem_r[y*W + x] = (x + 3 < W) ? mem_l[y*W + x + 3] : 8'($urandom);
    build_ref(0, SAD_THR);
    run_frame(0, 1'b0);
    checks++;
    if (q_addr.size() != NA || done_cnt != 1) begin
      errors++;
      $display("FAIL shift_frame got writes=%0d dones=%0d want %0d 1", q_addr.size(),
               done_cnt, NA);
    end
    for (int i = 0; i < q_addr.size() && i < NA; i++) begin
      checks++;
      if (q_addr[i] != exp_addr[i] || q_disp[i] != exp_disp[i] || q_cost[i] != exp_cost[i]) begin
        errors++;
        $display("FAIL shift_result i=%0d got a=%0d d=%0d c=%0d want a=%0d d=%0d c=%0d", i,
                 q_addr[i], q_disp[i], q_cost[i], exp_addr[i], exp_disp[i], exp_cost[i]);
      end
    end
  endtask

  task automatic test_flat_ssd();
    for (int i = 0; i < W*H; i++) begin
      mem_l[i] = 8'h80;
      mem_r[i] = 8'h80;
    end
    build_ref(1, SSD_THR);
    run_frame(1, 1'b0);
    checks++;
    if (q_addr.size() != NA || done_cnt != 1) begin
      errors++;
      $display("FAIL flat_frame got writes=%0d dones=%0d want %0d 1", q_addr.size(),
               done_cnt, NA);
    end
    for (int i = 0; i < q_addr.size() && i < NA; i++) begin
      checks++;
      if (q_addr[i] != exp_addr[i] || q_disp[i] != exp_disp[i] || q_cost[i] != exp_cost[i]) begin
        errors++;
        $display("FAIL flat_result i=%0d got a=%0d d=%0d c=%0d want a=%0d d=%0d c=%0d", i,
                 q_addr[i], q_disp[i], q_cost[i], exp_addr[i], exp_disp[i], exp_cost[i]);
      end
    end
  endtask

  task automatic test_thresh();
    for (int i = 0; i < W*H; i++) begin
      mem_l[i] = 8'($urandom);
      mem_r[i] = 8'($urandom);
    end
    // A few exact matches so both valid and invalid results appear.
    for (int r = 0; r < B; r++)
      for (int k = 0; k < B; k++) mem_r[(2+r)*W + 5 + k] = mem_l[(2+r)*W + 5 + k];
    build_ref(1, SSD_THR);
    run_frame(1, 1'b0);
    checks++;
    if (q_addr.size() != NA || done_cnt != 1) begin
      errors++;
      $display("FAIL thresh_frame got writes=%0d dones=%0d want %0d 1", q_addr.size(),
               done_cnt, NA);
    end
    for (int i = 0; i < q_addr.size() && i < NA; i++) begin
      checks++;
      if (q_addr[i] != exp_addr[i] || q_disp[i] != exp_disp[i] || q_cost[i] != exp_cost[i]) begin
        errors++;
        $display("FAIL thresh_result i=%0d got a=%0d d=%0d c=%0d want a=%0d d=%0d c=%0d", i,
                 q_addr[i], q_disp[i], q_cost[i], exp_addr[i], exp_disp[i], exp_cost[i]);
      end
    end
  endtask

  task automatic test_reset_abort();
    int stray;
    for (int i = 0; i < W*H; i++) begin
      mem_l[i] = 8'($urandom);
      mem_r[i] = 8'($urandom_range(0, 3)) + mem_l[i] / 2;
    end
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (we[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got we=%b busy=%b want 0 0", we[0], busy[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (60) begin
      @(negedge clk);
      if (we[0] || busy[0]) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL abort_quiet got active_cycles=%0d want 0", stray);
    end
    build_ref(0, SAD_THR);
    run_frame(0, 1'b1);
    checks++;
    if (q_addr.size() != NA || done_cnt != 1 || busy_err) begin
      errors++;
      $display("FAIL restart_frame got writes=%0d dones=%0d busy_err=%0d want %0d 1 0",
               q_addr.size(), done_cnt, busy_err, NA);
    end
    for (int i = 0; i < q_addr.size() && i < NA; i++) begin
      checks++;
      if (q_addr[i] != exp_addr[i] || q_disp[i] != exp_disp[i] || q_cost[i] != exp_cost[i]) begin
        errors++;
        $display("FAIL restart_result i=%0d got a=%0d d=%0d c=%0d want a=%0d d=%0d c=%0d", i,
                 q_addr[i], q_disp[i], q_cost[i], exp_addr[i], exp_disp[i], exp_cost[i]);
      end
    end
  endtask

  initial begin
    start[0] = 1'b0;
    start[1] = 1'b0;
    for (int i = 0; i < W*H; i++) begin
      mem_l[i] = 8'd0;
      mem_r[i] = 8'd0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    test_identical();
    test_timing();
    test_shift();
    test_flat_ssd();
    test_thresh();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
